// File: rtl/seg7_scan_arbiter.sv
// seg7_scan_arbiter: time-multiplexed scan controller for a 4-digit active-low
// 7-segment display, shared between source A (default owner) and source B
// (granted on request, switched only on frame boundaries). Adds per-digit
// blinking, a blank dead-time cycle at the start of every digit slot, and a
// once-per-frame pulse.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-low reset
//   en         - scan enable; 0 blanks the display and freezes all state
//   pat_a      - source A patterns, active-low, digit k at [7k+6:7k]
//   pat_b      - source B patterns, same format
//   req_b      - level request for display ownership by B
//   grant_b    - 1 while B owns the display
//   blink_mask - bit k=1 makes digit k blink
//   DIGIT      - active-low one-hot anode select (registered)
//   DISPLAY    - active-low segments of the selected digit (registered)
//   frame_done - high in the last cycle of each enabled frame
module seg7_scan_arbiter #(
  parameter int unsigned SCAN_CYCLES     = 100000,
  parameter int unsigned BLINK_FRAMES    = 64,
  parameter int unsigned MIN_HOLD_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [27:0] pat_a,
  input  logic [27:0] pat_b,
  input  logic        req_b,
  output logic        grant_b,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY,
  output logic        frame_done
);

  localparam int unsigned CNT_W  = $clog2(SCAN_CYCLES);
  localparam int unsigned FRM_W  = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD_FRAMES + 1);

  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } own_t;

  logic [CNT_W-1:0]  slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [FRM_W-1:0]  frm_q, frm_d, frm_inc;
  logic              blink_q, blink_d;
  own_t              own_q, own_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              slot_end, frame_end;
  logic [27:0]       pat_sel;
  logic [6:0]        seg;
  logic [3:0]        digit_d;
  logic [6:0]        display_d;

  // Slot/digit/frame counters and blink phase; all frozen while en=0.
  always_comb begin
    slot_d    = slot_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    blink_d   = blink_q;
    frm_inc   = frm_q + FRM_W'(1);
    slot_end  = (slot_q == CNT_W'(SCAN_CYCLES - 1));
    frame_end = en && slot_end && (idx_q == 2'd3);
    frame_done = rst && frame_end;
    if (en) begin
      if (slot_end) begin
        slot_d = '0;
        idx_d  = idx_q + 2'd1;
      end else begin
        slot_d = slot_q + CNT_W'(1);
      end
    end
    if (frame_end) begin
      if (frm_inc == FRM_W'(BLINK_FRAMES)) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_inc;
      end
    end
  end

  // Ownership FSM; decisions are taken only at an enabled frame end.
  always_comb begin
    own_d  = own_q;
    hold_d = hold_q;
    if (frame_end) begin
      unique case (own_q)
        OWN_A: begin
          if (req_b) begin
            own_d  = OWN_B;
            hold_d = HOLD_W'(MIN_HOLD_FRAMES - 1);
          end
        end
        OWN_B: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (!req_b) begin
            own_d = OWN_A;
          end
        end
        default: own_d = OWN_A;
      endcase
    end
  end

  // Next display value is computed from the next scan position so the
  // registered outputs line up with the counters; slot position 0 is dead time.
  always_comb begin
    digit_d   = DIGIT_OFF;
    display_d = SEG_OFF;
    pat_sel   = (own_d == OWN_B) ? pat_b : pat_a;
    unique case (idx_d)
      2'd0:    seg = pat_sel[6:0];
      2'd1:    seg = pat_sel[13:7];
      2'd2:    seg = pat_sel[20:14];
      default: seg = pat_sel[27:21];
    endcase
    if (en && (slot_d != '0)) begin
      digit_d   = ~(4'b0001 << idx_d);
      display_d = (blink_d && blink_mask[idx_d]) ? SEG_OFF : seg;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q  <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      own_q   <= OWN_A;
      hold_q  <= '0;
      grant_b <= 1'b0;
      DIGIT   <= DIGIT_OFF;
      DISPLAY <= SEG_OFF;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      grant_b <= (own_d == OWN_B);
      DIGIT   <= digit_d;
      DISPLAY <= display_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Testbench for seg7_scan_arbiter: a driver issues per-cycle stimulus and
// pushes the expected outputs from a position-based reference model into a
// queue; an independent monitor pops and compares on every falling edge.
module tb_seg7_scan_arbiter;

  localparam int unsigned SCAN   = 4;
  localparam int unsigned BLINK  = 2;
  localparam int unsigned HOLD   = 2;
  localparam int unsigned FRAME  = 4 * SCAN;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] disp;
    logic       g;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, req_b, grant_b, frame_done;
  logic [27:0] pat_a, pat_b;
  logic [3:0]  blink_mask, DIGIT;
  logic [6:0]  DISPLAY;

  seg7_scan_arbiter #(
    .SCAN_CYCLES    (SCAN),
    .BLINK_FRAMES   (BLINK),
    .MIN_HOLD_FRAMES(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pat_a     (pat_a),
    .pat_b     (pat_b),
    .req_b     (req_b),
    .grant_b   (grant_b),
    .blink_mask(blink_mask),
    .DIGIT     (DIGIT),
    .DISPLAY   (DISPLAY),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: p = enabled cycles since reset; ownership per frame.
  int          p = 0;
  bit          own = 0;
  int          streak = 0;
  bit          started = 0;
  logic        prev_rst = 1'b0, prev_en = 1'b0, prev_req = 1'b0;
  logic [27:0] prev_pa = '0, prev_pb = '0;
  logic [3:0]  prev_mask = '0;

  logic [27:0] cur_pa, cur_pb;
  logic [3:0]  cur_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, req);
    end
  endtask

  function automatic logic [6:0] getseg(input logic [27:0] pt, input int k);
    logic [27:0] t;
    t = pt >> (7 * k);
    return t[6:0];
  endfunction

  // Advance the model across one clock edge using the previous cycle's inputs.
  task automatic model_edge();
    if (!prev_rst) begin
      started = 1;
      p = 0;
      own = 0;
      streak = 0;
    end else if (prev_en) begin
      if (p % FRAME == FRAME - 1) begin
        if (!own) begin
          if (prev_req) begin
            own = 1;
            streak = 1;
          end
        end else if (streak >= HOLD && !prev_req) begin
          own = 0;
          streak = 0;
        end else begin
          streak++;
        end
      end
      p++;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rq);
    exp_t x;
    int   k;
    bit   blank;
    int   phase;
    logic [3:0] one;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; en = e; req_b = rq;
    pat_a = cur_pa; pat_b = cur_pb; blink_mask = cur_mask;
    if (started) begin
      one   = 4'b0001;
      k     = (p / SCAN) % 4;
      blank = !prev_rst || !prev_en || (p % SCAN == 0);
      phase = ((p / FRAME) / BLINK) % 2;
      x.dig  = blank ? 4'b1111 : ~(one << k);
      x.disp = (blank || (phase == 1 && prev_mask[k])) ? 7'h7F
               : getseg(own ? prev_pb : prev_pa, k);
      x.g    = own;
      x.fd   = r && e && (p % FRAME == FRAME - 1);
      exp_q.push_back(x);
    end
    prev_rst = r; prev_en = e; prev_req = rq;
    prev_pa = cur_pa; prev_pb = cur_pb; prev_mask = cur_mask;
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("DIGIT", 32'(DIGIT), 32'(mon_e.dig));
      chk("DISPLAY", 32'(DISPLAY), 32'(mon_e.disp));
      chk("grant_b", 32'(grant_b), 32'(mon_e.g));
      chk("frame_done", 32'(frame_done), 32'(mon_e.fd));
    end
  end

  initial begin
    bit   ok;
    logic rr;
    rst = 1'b0; en = 1'b0; req_b = 1'b0;
    cur_pa   = {7'h08, 7'h04, 7'h02, 7'h01};
    cur_pb   = {7'h3F, 7'h06, 7'h5B, 7'h4F};
    cur_mask = 4'b0100;
    pat_a = cur_pa; pat_b = cur_pb; blink_mask = cur_mask;

    // Reset, then scan; req_b held from mid frame 0 into frame 1.
    repeat (2) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6 * FRAME; i++) step(1'b1, 1'b1, (i >= 6 && i < 20));

    // One-cycle req_b pulse away from a frame end must be ignored.
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b1, (i == 5));

    // Freeze at slot 2 cycle 2 for 5 cycles, then resume.
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((p + 1) % FRAME == 2 * SCAN + 2) begin ok = 1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    chk("align_en_test", 32'(ok), 32'd1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (3 * FRAME) step(1'b1, 1'b1, 1'b0);

    // Randomized operation.
    rr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      if ($urandom_range(0, 7) == 0) cur_pa = 28'($urandom());
      if ($urandom_range(0, 7) == 0) cur_pb = 28'($urandom());
      if ($urandom_range(0, 49) == 0) cur_mask = 4'($urandom());
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0), rr);
    end

    // Reset mid-frame while B owns the display.
    ok = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (own && (p % FRAME == 6)) begin ok = 1; break; end
      step(1'b1, 1'b1, 1'b1);
    end
    chk("reach_grant", 32'(ok), 32'd1);
    step(1'b0, 1'b1, 1'b1);
    repeat (2 * FRAME) step(1'b1, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
